// File: rtl/screen_sequencer_pkg.sv
// screen_sequencer_pkg: screen state encoding, default frame counts and counter sizing
package screen_sequencer_pkg;
  typedef enum logic [2:0] {TITLE, BLANK_TO_GAME, GAME, BLANK_TO_END, HIGHSCORE} state_t;
  localparam int BLANK_FRAMES_DEF = 30;
  localparam int HS_FRAMES_DEF = 300;
  function automatic int cnt_width(input int a, input int b);
    return $clog2((a > b ? a : b) + 1);
  endfunction
endpackage

// File: rtl/screen_sequencer_frame_timer.sv
// frame_timer: saturating vsync frame counter with clear and terminal-count flag
module frame_timer #(
  parameter int W = 9
) (
  input  logic         pclk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         tick,
  input  logic [W-1:0] limit,
  output logic         tc
);
  localparam logic [W-1:0] ONE = W'(1);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = clr ? '0 : (tick && cnt_q < limit) ? cnt_q + ONE : cnt_q;
  end
  // tc flags the tick that completes the count, so the caller moves on that same edge
  assign tc = tick && cnt_q >= limit - ONE;
  always_ff @(posedge pclk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/screen_sequencer.sv
// screen_sequencer: title/game/high-score screen FSM; define SCREEN_ATTRACT_EN for idle-title attract mode
module screen_sequencer
  import screen_sequencer_pkg::*;
#(
  parameter int BLANK_FRAMES = BLANK_FRAMES_DEF,
  parameter int HS_FRAMES    = HS_FRAMES_DEF,
  parameter int SCORE_W      = 16
) (
  input  logic               pclk,
  input  logic               rst_n,
  input  logic               vsync_tick,
  input  logic               btn_start,
  input  logic               game_over,
  input  logic [SCORE_W-1:0] score,
  output logic               title_sel,
  output logic               game_sel,
  output logic               highscore_sel,
  output logic               wait_sel,
  output logic               game_rst,
  output logic [SCORE_W-1:0] best_score,
  output logic               new_record
);
  localparam int W = cnt_width(BLANK_FRAMES, HS_FRAMES);
  state_t state_q, state_d;
  logic btn_q, btn_d, rec_q, rec_d, game_rst_q, game_rst_d, new_record_q, new_record_d;
  logic tc, start_rise;
  logic [SCORE_W-1:0] best_q, best_d;
  logic [3:0] sel_q, sel_d;
  logic [W-1:0] limit;
  assign start_rise = btn_start && !btn_q;
  assign limit = (state_q == TITLE || state_q == HIGHSCORE) ? W'(HS_FRAMES) : W'(BLANK_FRAMES);
  frame_timer #(.W(W)) u_timer (
    .pclk  (pclk),
    .rst_n (rst_n),
    .clr   (state_d != state_q),
    .tick  (vsync_tick),
    .limit (limit),
    .tc    (tc)
  );
  always_comb begin
    state_d = state_q;
    best_d = best_q;
    rec_d = rec_q;
    btn_d = btn_start;
    case (state_q)
      TITLE: state_d = start_rise ? BLANK_TO_GAME :
`ifdef SCREEN_ATTRACT_EN
                       tc ? HIGHSCORE :
`endif
                       TITLE;
      BLANK_TO_GAME: state_d = tc ? GAME : BLANK_TO_GAME;
      GAME: if (game_over) begin
        state_d = BLANK_TO_END;
        if (score > best_q) begin
          best_d = score;
          rec_d = 1'b1;
        end
      end
      BLANK_TO_END: state_d = tc ? (rec_q ? HIGHSCORE : TITLE) : BLANK_TO_END;
      HIGHSCORE: if (tc || start_rise) begin
        state_d = TITLE;
        rec_d = 1'b0;
      end
      default: state_d = TITLE;
    endcase
    sel_d = {state_d == TITLE, state_d == GAME, state_d == HIGHSCORE,
             state_d == BLANK_TO_GAME || state_d == BLANK_TO_END};
    game_rst_d = state_q == BLANK_TO_GAME && state_d == GAME;
    new_record_d = state_d == HIGHSCORE && rec_d;
  end
  always_ff @(posedge pclk or negedge rst_n)
    if (!rst_n) begin
      state_q <= TITLE;
      btn_q <= 1'b0;
      best_q <= '0;
      rec_q <= 1'b0;
      sel_q <= 4'b1000;
      game_rst_q <= 1'b0;
      new_record_q <= 1'b0;
    end else begin
      state_q <= state_d;
      btn_q <= btn_d;
      best_q <= best_d;
      rec_q <= rec_d;
      sel_q <= sel_d;
      game_rst_q <= game_rst_d;
      new_record_q <= new_record_d;
    end
  assign {title_sel, game_sel, highscore_sel, wait_sel} = sel_q;
  assign game_rst = game_rst_q;
  assign best_score = best_q;
  assign new_record = new_record_q;
endmodule

// File: tb/tb_screen_sequencer.sv
// tb_screen_sequencer: directed scenarios plus random play checked against a screen-level reference model
module tb_screen_sequencer;
  localparam int BF = 30, HF = 300, SW = 16;
  logic pclk = 0, rst_n = 1, vsync_tick = 0, btn_start = 0, game_over = 0;
  logic [SW-1:0] score = 0;
  logic title_sel, game_sel, highscore_sel, wait_sel, game_rst, new_record;
  logic [SW-1:0] best_score;
  screen_sequencer dut (
    .pclk          (pclk),
    .rst_n         (rst_n),
    .vsync_tick    (vsync_tick),
    .btn_start     (btn_start),
    .game_over     (game_over),
    .score         (score),
    .title_sel     (title_sel),
    .game_sel      (game_sel),
    .highscore_sel (highscore_sel),
    .wait_sel      (wait_sel),
    .game_rst      (game_rst),
    .best_score    (best_score),
    .new_record    (new_record)
  );
  always #5 pclk = ~pclk;
  int n_chk = 0, n_fail = 0, cnt = 0;
  bit b = 0;
  // model: screen 0 title, 1 blank before game, 2 game, 3 blank after game, 4 high score
  int m_scr, m_left, m_best;
  bit m_rec, m_prev, m_pulse;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cnt, got, exp);
    end
  endtask
  task automatic model_reset();
    m_scr = 0; m_left = HF; m_best = 0; m_rec = 0; m_prev = 0; m_pulse = 0;
  endtask
  task automatic model_step(input bit vs, input bit btn, input bit go, input int sc);
    bit rise;
    rise = btn && !m_prev;
    m_prev = btn;
    m_pulse = 0;
    if (m_scr == 0) begin
      if (rise) begin m_scr = 1; m_left = BF; end
`ifdef SCREEN_ATTRACT_EN
      else if (vs) begin
        m_left--;
        if (m_left == 0) begin m_scr = 4; m_left = HF; end
      end
`endif
    end else if (m_scr == 1) begin
      if (vs) m_left--;
      if (vs && m_left == 0) begin m_scr = 2; m_pulse = 1; end
    end else if (m_scr == 2) begin
      if (go) begin
        m_scr = 3; m_left = BF;
        if (sc > m_best) begin m_best = sc; m_rec = 1; end
      end
    end else if (m_scr == 3) begin
      if (vs) m_left--;
      if (vs && m_left == 0) begin m_scr = m_rec ? 4 : 0; m_left = HF; end
    end else begin
      if (vs) m_left--;
      if (rise || (vs && m_left == 0)) begin m_scr = 0; m_rec = 0; m_left = HF; end
    end
  endtask
  task automatic check_outs();
    check("sel", {title_sel, game_sel, highscore_sel, wait_sel},
          {m_scr == 0, m_scr == 2, m_scr == 4, m_scr == 1 || m_scr == 3});
    check("game_rst", game_rst, m_pulse);
    check("best_score", best_score, m_best);
    check("new_record", new_record, m_scr == 4 && m_rec);
  endtask
  task automatic cyc(input bit go, input logic [SW-1:0] sc);
    bit vs;
    vs = (cnt % 4 == 0);
    vsync_tick = vs; btn_start = b; game_over = go; score = sc;
    @(posedge pclk);
    model_step(vs, b, go, int'(sc));
    cnt++;
    @(negedge pclk);
    check_outs();
  endtask
  task automatic idle(input int ticks);
    repeat (ticks * 4) cyc(0, SW'($urandom));
  endtask
  task automatic to_ph2();
    while (cnt % 4 != 2) cyc(0, 0);
  endtask
  task automatic async_reset();
    #2 rst_n = 0;
    #1;
    check("rst_sel", {title_sel, game_sel, highscore_sel, wait_sel}, 4'b1000);
    check("rst_game_rst", game_rst, 0);
    check("rst_best", best_score, 0);
    check("rst_new_record", new_record, 0);
    b = 0; btn_start = 0; game_over = 0; vsync_tick = 0;
    @(posedge pclk);
    @(negedge pclk);
    rst_n = 1;
    model_reset();
  endtask
  initial begin
    model_reset();
    @(negedge pclk);
    async_reset();
    // first game: start edge, blank, game, record score 100, high score screen
    to_ph2(); b = 1; cyc(0, 0);
    idle(31);
    to_ph2(); cyc(1, 100);
    idle(BF + HF + 10);
    // start still held on return to title: no new game until released and re-pressed
    b = 0; idle(1);
    to_ph2(); b = 1; cyc(0, 0);
    idle(31);
    to_ph2(); cyc(1, 100);
    idle(35);
    // reset during the blank before a game
    b = 0; to_ph2(); b = 1; cyc(0, 0);
    idle(10);
    @(negedge pclk);
    async_reset();
    idle(HF + 5);
    // random play: start toggles and game_over pulses at arbitrary states
    for (int i = 0; i < 16000; i++) begin
      bit go;
      logic [SW-1:0] sc;
      go = (cnt % 4 == 2) && $urandom_range(0, 24) == 0;
      if (cnt % 4 == 2 && $urandom_range(0, 19) == 0) b = ~b;
      case ($urandom_range(0, 3))
        0: sc = SW'(m_best);
        1: sc = SW'(m_best + 1);
        2: sc = SW'($urandom_range(0, 199));
        default: sc = (m_best > 0) ? SW'(m_best - 1) : 0;
      endcase
      cyc(go, sc);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/screen_sequencer.md
SCREEN_SEQUENCER -- requirements
Module: screen_sequencer

Interface
REQ-001 SHALL have parameter BLANK_FRAMES, default 30, frames of blank (Wait) between screens.
REQ-002 SHALL have parameter HS_FRAMES, default 300, frames the high-score screen is held.
REQ-003 SHALL have parameter SCORE_W, default 16, score width in bits.
REQ-004 SHALL have port pclk  in  1  pixel clock, the only clock.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port vsync_tick  in  1  one-cycle pulse per frame.
REQ-007 SHALL have port btn_start  in  1  start button level, already synchronised to pclk.
REQ-008 SHALL have port game_over  in  1  one-cycle pulse from game logic.
REQ-009 SHALL have port score  in  SCORE_W  final score, valid when game_over=1.
REQ-010 SHALL have ports title_sel, game_sel, highscore_sel, wait_sel  out  1 each  screen selects to the screen mux.
REQ-011 SHALL have port game_rst  out  1  one-cycle pulse that clears game logic.
REQ-012 SHALL have port best_score  out  SCORE_W  stored record.
REQ-013 SHALL have port new_record  out  1  high while a new record is displayed.

Function
REQ-014 SHALL implement states TITLE, BLANK_TO_GAME, GAME, BLANK_TO_END, HIGHSCORE.
REQ-015 SHALL drive outputs from registered state: exactly one of title_sel/game_sel/highscore_sel/wait_sel high; both BLANK states drive wait_sel.
REQ-016 SHALL detect a btn_start rising edge (previous-level register); a held level SHALL NOT trigger.
REQ-017 TITLE: on rising edge -> BLANK_TO_GAME, frame counter cleared.
REQ-018 BLANK_TO_GAME: count vsync_tick; at count BLANK_FRAMES -> GAME with game_rst high for exactly that one cycle.
REQ-019 GAME: on game_over -> BLANK_TO_END; if score > best_score, load best_score and set record flag in the same edge; score equal to best is no record.
REQ-020 BLANK_TO_END: after BLANK_FRAMES ticks -> HIGHSCORE if record flag set, else TITLE.
REQ-021 HIGHSCORE: new_record=1; after HS_FRAMES ticks, or on start rising edge, -> TITLE and clear record flag.
REQ-022 SHALL have every transition take effect at the clock edge sampling the event (latency 1 cycle to outputs).
REQ-023 SHALL NOT count a vsync_tick arriving in the state-entry cycle.
REQ-024 SHALL size the frame counter to hold max(BLANK_FRAMES, HS_FRAMES) without wrap; it SHALL saturate, never wrap.
REQ-025 SHALL ignore game_over outside GAME and btn_start in BLANK states and GAME.
REQ-026 SHALL, when game_over and a start edge coincide in GAME, take game_over.

Reset
REQ-027 SHALL on rst_n=0 enter TITLE: title_sel=1, other selects 0, game_rst=0, best_score=0, new_record=0, counter=0, edge register=0.
REQ-028 SHALL, when reset is asserted mid-operation, return to the TITLE state above within the same cycle (asynchronously), with no pending game_rst.

Configuration
REQ-029 SHALL support macro SCREEN_ATTRACT_EN: when defined, TITLE with no start edge for HS_FRAMES ticks -> HIGHSCORE with new_record=0, then back per REQ-021; when undefined, TITLE waits indefinitely.

Structure
REQ-030 SHALL take the state encoding typedef and default frame constants from the shared game package.
REQ-031 SHALL place the vsync frame counter in sub-module frame_timer (clear, tick, terminal-count compare).

Verification
REQ-032 Reset, then start edge, 30 ticks -> wait_sel 30 frames, then game_sel=1 with one game_rst pulse.
REQ-033 GAME, game_over with score=100 and best=0 -> 30 blank frames, highscore_sel=1, best_score=100, new_record=1, TITLE after 300 ticks.
REQ-034 Second game, score=100 (best 100) -> blank, then title_sel=1, best unchanged.
REQ-035 btn_start held high across return to TITLE -> stays TITLE until released and re-pressed.
REQ-036 rst_n low during BLANK_TO_GAME -> title_sel=1, game_rst never pulses, best_score=0.
REQ-037 With SCREEN_ATTRACT_EN, idle TITLE 300 ticks -> highscore_sel=1, new_record=0.
